log_window_gen: RTL and testbench
=================================

# log_window_gen

Raster-to-window front end for the 5x5 LoG edge filter. It accepts one 8-bit pixel per handshake in raster order and buffers four image lines internally. For every pixel position whose full 5x5 neighbourhood lies inside the frame, it emits the 200-bit packed window the filter consumes, together with the centre coordinate. It sits between the JPEG decoder's pixel output and the edge filter.

## Interface
Parameters:
- IMG_WIDTH, 64, pixels per line; must be >= 5.
- IMG_HEIGHT, 64, lines per frame; must be >= 5.
- CW, 16, width of the coordinate counters; must satisfy 2^CW >= max(IMG_WIDTH, IMG_HEIGHT).

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_pix  in  8  input pixel.
- in_sof  in  1  start of frame; qualified by in_valid.
- in_valid  in  1  in_pix and in_sof are valid.
- in_ready  out  1  block can accept a pixel this cycle.
- win_out  out  200  packed 5x5 window.
- win_x  out  CW  centre column of win_out.
- win_y  out  CW  centre row of win_out.
- win_valid  out  1  win_out, win_x and win_y are valid.
- win_ready  in  1  downstream accepts the window.
- frame_done  out  1  one-cycle pulse after the last pixel of a frame is accepted.

## Operation
- Accept condition: in_valid && in_ready.
- in_ready = !win_valid || win_ready. There is a single output register and no skid buffer.
- Counters col (0..IMG_WIDTH-1) and row (0..IMG_HEIGHT-1) address the pixel being accepted.
  - Advance col on every accept.
  - At the end of a line, col wraps to 0 and row increments.
  - After (IMG_WIDTH-1, IMG_HEIGHT-1), both wrap to 0.
- in_sof on an accepted pixel forces that pixel to position (0,0), overriding the counters. Counting continues from (1,0).
- Line buffers lb0..lb3, each IMG_WIDTH x 8, addressed by col. On accept:
  - lb0[col] <= in_pix
  - lbN[col] <= lb(N-1)[col]
  - Reads return the old contents. lb3 holds the oldest line.
- Window registers w[r][c], r,c in 0..4. On accept:
  - Every row shifts left: w[r][c] <= w[r][c+1].
  - The new column is w[0..4][4] <= {lb3[col], lb2[col], lb1[col], lb0[col], in_pix}.
  - Row 0 is the top (oldest) line; column 0 is the leftmost pixel.
- Packing: element k = r*5+c occupies win_out[8k+7:8k]. The centre pixel is win_out[103:96].
- Emit condition: the accepted pixel is at col >= 4 and row >= 4.
  - win_valid <= 1, win_x <= col-2, win_y <= row-2.
  - win_out reflects the register state after the shift.
- When win_valid && win_ready and no new emission occurs, win_valid <= 0.
- Border positions (centre within 2 of any edge) are never emitted. Each frame yields exactly (IMG_WIDTH-4)*(IMG_HEIGHT-4) windows.
- Windows never mix lines from the previous frame, because row < 4 suppresses emission.
- frame_done is asserted the cycle after the pixel at (IMG_WIDTH-1, IMG_HEIGHT-1) is accepted.

## Timing
- Latency: the window is valid the cycle after the accept of its bottom-right pixel.
- Throughput: one window per cycle when win_ready is held high.
- Backpressure: while win_valid && !win_ready, the following must hold:
  - in_ready = 0.
  - win_out, win_x and win_y are stable.
  - All counters, line buffers and window registers are frozen.
- Reset values:
  - win_valid = 0, frame_done = 0.
  - win_x = 0, win_y = 0, win_out = 0.
  - col = 0, row = 0.
  - in_ready = 1 from the first cycle after reset deassertion.
  - Line-buffer contents are not reset; they are don't-care.
- Reset mid-frame drops any pending window. The next accepted pixel is (0,0) regardless of in_sof.
- in_sof mid-frame abandons the partial frame without asserting frame_done. Output is suppressed until row 4 of the new frame.

## Structure
- Shared package: PIX_W=8, WIN_N=5, WIN_BITS=200, the function idx(r,c)=r*5+c, and the centre index 12.
- Sub-module line_buf: a single IMG_WIDTH x 8 array with one read and one write at the same address in the same cycle, read-before-write, and an enable port. It is instantiated four times.
- The FSM is implicit in the counters; there is no explicit state enum.

## Test plan
- Ramp frame, IMG_WIDTH=8, IMG_HEIGHT=6, pixel value = y*8+x, win_ready=1:
  - Exactly 8 windows are produced.
  - First window: (win_x, win_y) = (2,2), [7:0]=0, [103:96]=18, [199:192]=36.
  - Last window: (5,3), centre byte 29.
  - frame_done pulses once.
- Same frame with win_ready toggled pseudo-randomly: window contents and order are identical to the unstalled run, and no pixel is lost while in_ready=0.
- Constant image of 200 followed by a second frame of 50 without reset: every window of frame 2 has all 25 bytes equal to 50.
- in_sof asserted at pixel 20 of a frame: no windows from the aborted frame, no frame_done, and the next frame produces a full set of 8 windows.
- rst asserted for 1 cycle while win_valid=1 and win_ready=0: win_valid=0 in the same cycle, and the next frame yields the first window (2,2) correctly.
- Back-to-back frames with win_ready=1: exactly one frame_done per frame, and windows are emitted at a sustained 1 per cycle within each interior line.

Source files
------------

// File: rtl/log_window_gen_pkg.sv
// Shared constants and helpers for the 5x5 LoG window front end.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package log_window_gen_pkg;

   localparam int PIX_W      = 8;
   localparam int WIN_N      = 5;
   localparam int WIN_BITS   = PIX_W * WIN_N * WIN_N;
   localparam int CENTER_IDX = 12;

   // Byte index of window element (r,c); row 0 is the oldest line, column 0 the leftmost pixel.
   function automatic int idx(input int r, input int c);
      return r * WIN_N + c;
   endfunction

endpackage

// File: rtl/log_window_gen_line_buf.sv
// One image line of pixel storage, read-before-write at a shared address.
// Latency: combinational read of the old contents; write lands at the clock edge.
// Backpressure: none internally; i_en is low whenever the owner is stalled.
// Ports: clk, i_en (write enable), i_addr (column), i_wdat (pixel in), o_rdat (old pixel out).
module log_window_gen_line_buf
   import log_window_gen_pkg::*;
#(
   parameter int DEPTH = 64,
   parameter int AW    = 6
) (
   input  logic             clk,
   input  logic             i_en,
   input  logic [AW-1:0]    i_addr,
   input  logic [PIX_W-1:0] i_wdat,
   output logic [PIX_W-1:0] o_rdat
);

   // Contents are deliberately not reset; rows from before reset are never emitted.
   logic [PIX_W-1:0] r_mem [DEPTH];

   assign o_rdat = r_mem[i_addr];

   always_ff @(posedge clk) begin
      if (i_en) begin
         r_mem[i_addr] <= i_wdat;
      end
   end

endmodule

// File: rtl/log_window_gen.sv
// Raster pixels in, 5x5 packed neighbourhood windows (plus centre x/y) out for the LoG filter.
// Latency: window valid one cycle after the accept of its bottom-right pixel.
// Backpressure: single output register; in_ready = !win_valid || win_ready, so a stalled window freezes everything.
// Ports: clk/rst; in_pix/in_sof/in_valid/in_ready pixel input; win_out/win_x/win_y/win_valid/win_ready window output; frame_done pulse.
module log_window_gen
   import log_window_gen_pkg::*;
#(
   parameter int IMG_WIDTH  = 64,
   parameter int IMG_HEIGHT = 64,
   parameter int CW         = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [PIX_W-1:0]    in_pix,
   input  logic                in_sof,
   input  logic                in_valid,
   output logic                in_ready,
   output logic [WIN_BITS-1:0] win_out,
   output logic [CW-1:0]       win_x,
   output logic [CW-1:0]       win_y,
   output logic                win_valid,
   input  logic                win_ready,
   output logic                frame_done
);

   localparam int            AW       = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
   localparam int            LB_N     = WIN_N - 1;
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
   localparam logic [CW-1:0] ROW_LAST = CW'(IMG_HEIGHT - 1);
   localparam logic [CW-1:0] EDGE     = CW'(WIN_N - 1);
   localparam logic [CW-1:0] HALF     = CW'(WIN_N / 2);

   logic [CW-1:0]       r_col;
   logic [CW-1:0]       r_row;
   logic [WIN_BITS-1:0] r_win;
   logic [CW-1:0]       r_win_x;
   logic [CW-1:0]       r_win_y;
   logic                r_win_valid;
   logic                r_frame_done;

   logic                w_acc;
   logic                w_emit;
   logic                w_last;
   logic [CW-1:0]       w_col;
   logic [CW-1:0]       w_row;
   logic [CW-1:0]       w_col_nxt;
   logic [CW-1:0]       w_row_nxt;
   logic [PIX_W-1:0]    w_lb_rd [LB_N];
   logic [PIX_W-1:0]    w_lb_wr [LB_N];
   logic [WIN_BITS-1:0] w_win_nxt;

   assign in_ready   = !r_win_valid || win_ready;
   assign w_acc      = in_valid && in_ready;

   // Start of frame overrides the running counters so a partial frame is simply abandoned.
   assign w_col      = in_sof ? '0 : r_col;
   assign w_row      = in_sof ? '0 : r_row;

   // row < 4 suppresses output, so stale lines from an earlier frame never reach a window.
   assign w_emit     = w_acc && (w_col >= EDGE) && (w_row >= EDGE);
   assign w_last     = (w_col == COL_LAST) && (w_row == ROW_LAST);

   always_comb begin
      w_col_nxt = w_col + CW'(1);
      w_row_nxt = w_row;
      if (w_col == COL_LAST) begin
         w_col_nxt = '0;
         w_row_nxt = (w_row == ROW_LAST) ? '0 : w_row + CW'(1);
      end
   end

   // Line buffers form a vertical shift chain: lb0 holds the newest line, lb3 the oldest.
   assign w_lb_wr[0] = in_pix;
   for (genvar g = 1; g < LB_N; g++) begin : g_lb_chain
      assign w_lb_wr[g] = w_lb_rd[g-1];
   end

   for (genvar g = 0; g < LB_N; g++) begin : g_lb
      log_window_gen_line_buf #(
         .DEPTH (IMG_WIDTH),
         .AW    (AW)
      ) u_lb (
         .clk    (clk),
         .i_en   (w_acc),
         .i_addr (w_col[AW-1:0]),
         .i_wdat (w_lb_wr[g]),
         .o_rdat (w_lb_rd[g])
      );
   end

   // Shift every window row left by one pixel and insert the new vertical column on the right.
   always_comb begin
      w_win_nxt = r_win;
      for (int r = 0; r < WIN_N; r++) begin
         for (int c = 0; c < WIN_N - 1; c++) begin
            w_win_nxt[PIX_W*idx(r, c) +: PIX_W] = r_win[PIX_W*idx(r, c + 1) +: PIX_W];
         end
      end
      w_win_nxt[PIX_W*idx(0, WIN_N-1) +: PIX_W] = w_lb_rd[3];
      w_win_nxt[PIX_W*idx(1, WIN_N-1) +: PIX_W] = w_lb_rd[2];
      w_win_nxt[PIX_W*idx(2, WIN_N-1) +: PIX_W] = w_lb_rd[1];
      w_win_nxt[PIX_W*idx(3, WIN_N-1) +: PIX_W] = w_lb_rd[0];
      w_win_nxt[PIX_W*idx(4, WIN_N-1) +: PIX_W] = in_pix;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_col        <= '0;
         r_row        <= '0;
         r_win        <= '0;
         r_win_x      <= '0;
         r_win_y      <= '0;
         r_win_valid  <= 1'b0;
         r_frame_done <= 1'b0;
      end else begin
         r_frame_done <= w_acc && w_last;
         if (w_acc) begin
            r_col <= w_col_nxt;
            r_row <= w_row_nxt;
            r_win <= w_win_nxt;
         end
         if (w_emit) begin
            r_win_valid <= 1'b1;
            r_win_x     <= w_col - HALF;
            r_win_y     <= w_row - HALF;
         end else if (win_ready) begin
            r_win_valid <= 1'b0;
         end
      end
   end

   assign win_out    = r_win;
   assign win_x      = r_win_x;
   assign win_y      = r_win_y;
   assign win_valid  = r_win_valid;
   assign frame_done = r_frame_done;

endmodule

// File: tb/tb_log_window_gen.sv
// Randomised bench for log_window_gen with an image-array reference model and a window scoreboard.
// Latency: n/a (testbench).
// Backpressure: win_ready is driven pseudo-randomly per scenario.
module tb_log_window_gen;

   localparam int W    = 8;
   localparam int H    = 6;
   localparam int CW   = 16;
   localparam int NWIN = (W - 4) * (H - 4);

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic [7:0]     in_pix;
   logic           in_sof;
   logic           in_valid;
   logic           in_ready;
   logic [199:0]   win_out;
   logic [CW-1:0]  win_x;
   logic [CW-1:0]  win_y;
   logic           win_valid;
   logic           win_ready;
   logic           frame_done;

   log_window_gen #(
      .IMG_WIDTH  (W),
      .IMG_HEIGHT (H),
      .CW         (CW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .in_pix     (in_pix),
      .in_sof     (in_sof),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .win_out    (win_out),
      .win_x      (win_x),
      .win_y      (win_y),
      .win_valid  (win_valid),
      .win_ready  (win_ready),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [CW-1:0] x;
      logic [CW-1:0] y;
      logic [199:0]  w;
   } win_t;

   win_t exp_q[$];
   win_t got_q[$];

   int n_vec   = 0;
   int n_err   = 0;
   int n_rst   = 0;
   int mon_fd  = 0;
   int exp_fd  = 0;
   int mon_run = 0;
   int max_run = 0;
   int mc      = 0;
   int mr      = 0;
   logic [7:0] img [H][W];

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   // Reference: store the pixel into a frame image and cut the window straight out of it.
   task automatic model_accept(input logic [7:0] p, input logic sof);
      win_t e;
      if (sof) begin
         mc = 0;
         mr = 0;
      end
      img[mr][mc] = p;
      if (mc >= 4 && mr >= 4) begin
         e.x = CW'(mc - 2);
         e.y = CW'(mr - 2);
         e.w = '0;
         for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
               e.w[8*(r*5+c) +: 8] = img[mr-4+r][mc-4+c];
         exp_q.push_back(e);
      end
      if (mc == W - 1 && mr == H - 1) exp_fd++;
      if (mc == W - 1) begin
         mc = 0;
         mr = (mr == H - 1) ? 0 : mr + 1;
      end else begin
         mc++;
      end
   endtask

   // Entered and left at a falling edge; holds the pixel until the DUT takes it.
   task automatic send_pix(input logic [7:0] p, input logic sof, input int stall_pct);
      int tries;
      tries    = 0;
      in_pix   = p;
      in_sof   = sof;
      in_valid = 1'b1;
      forever begin
         win_ready = ($urandom_range(0, 99) >= stall_pct);
         #1;
         if (in_ready) begin
            model_accept(p, sof);
            @(negedge clk);
            break;
         end
         @(negedge clk);
         tries++;
         if (tries > 200) begin
            n_vec++;
            n_err++;
            $display("FAIL accept_timeout: pixel %0h not taken after %0d cycles", p, tries);
            break;
         end
      end
   endtask

   task automatic send_frame(input bit ramp, input logic [7:0] val, input logic sof,
                             input int stall_pct, input int npix);
      for (int i = 0; i < npix; i++)
         send_pix(ramp ? 8'(i) : val, (i == 0) ? sof : 1'b0, stall_pct);
   endtask

   task automatic idle(input int n);
      in_valid  = 1'b0;
      in_sof    = 1'b0;
      win_ready = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   // Monitor: pops the scoreboard on every output handshake, checks stall stability.
   initial begin
      win_t g;
      win_t e;
      win_t hold;
      bit   hold_vld;
      int   hold_rst;
      hold_vld = 1'b0;
      hold_rst = 0;
      forever begin
         @(negedge clk);
         #3;
         if (hold_vld && n_rst == hold_rst)
            check("stall_stable", {win_valid, win_x, win_y, win_out},
                  {1'b1, hold.x, hold.y, hold.w});
         hold_vld = 1'b0;
         if (win_valid && !win_ready) begin
            check("stall_in_ready", in_ready, 0);
            hold.x   = win_x;
            hold.y   = win_y;
            hold.w   = win_out;
            hold_vld = 1'b1;
            hold_rst = n_rst;
         end
         if (frame_done) mon_fd++;
         if (win_valid) begin
            mon_run++;
            if (mon_run > max_run) max_run = mon_run;
         end else begin
            mon_run = 0;
         end
         if (win_valid && win_ready) begin
            g.x = win_x;
            g.y = win_y;
            g.w = win_out;
            got_q.push_back(g);
            if (exp_q.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL unexpected_window: got (%0d,%0d), required none", g.x, g.y);
            end else begin
               e = exp_q.pop_front();
               check("window", {g.x, g.y, g.w}, {e.x, e.y, e.w});
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int   base;
      int   fd0;
      win_t ref_q[$];
      in_valid  = 1'b0;
      in_sof    = 1'b0;
      in_pix    = '0;
      win_ready = 1'b1;
      rst       = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      check("rst_in_ready",   in_ready,   1);
      check("rst_win_valid",  win_valid,  0);
      check("rst_frame_done", frame_done, 0);
      check("rst_win_out",    win_out,    0);
      check("rst_win_xy",     {win_x, win_y}, 0);
      @(negedge clk);

      // Ramp frame, no stalls.
      base = got_q.size();
      fd0  = mon_fd;
      send_frame(1'b1, 8'd0, 1'b1, 0, W * H);
      idle(10);
      check("ramp_nwin", got_q.size() - base, NWIN);
      if (got_q.size() >= base + NWIN) begin
         check("ramp_first_xy",   {got_q[base].x, got_q[base].y}, {16'd2, 16'd2});
         check("ramp_first_tl",   got_q[base].w[7:0],     0);
         check("ramp_first_ctr",  got_q[base].w[103:96],  18);
         check("ramp_first_br",   got_q[base].w[199:192], 36);
         check("ramp_last_xy",    {got_q[base+NWIN-1].x, got_q[base+NWIN-1].y}, {16'd5, 16'd3});
         check("ramp_last_ctr",   got_q[base+NWIN-1].w[103:96], 29);
         for (int i = 0; i < NWIN; i++) ref_q.push_back(got_q[base+i]);
      end
      check("ramp_frame_done", mon_fd - fd0, 1);

      // Same ramp with random backpressure.
      base = got_q.size();
      fd0  = mon_fd;
      send_frame(1'b1, 8'd0, 1'b1, 50, W * H);
      idle(20);
      check("stall_nwin", got_q.size() - base, NWIN);
      if (got_q.size() >= base + NWIN && ref_q.size() == NWIN)
         for (int i = 0; i < NWIN; i++)
            check($sformatf("stall_vs_ref_%0d", i),
                  {got_q[base+i].x, got_q[base+i].y, got_q[base+i].w},
                  {ref_q[i].x, ref_q[i].y, ref_q[i].w});
      check("stall_frame_done", mon_fd - fd0, 1);

      // Constant 200 frame then constant 50 frame, no reset between.
      base = got_q.size();
      send_frame(1'b0, 8'd200, 1'b1, 30, W * H);
      send_frame(1'b0, 8'd50,  1'b1, 30, W * H);
      idle(20);
      check("const_nwin", got_q.size() - base, 2 * NWIN);
      if (got_q.size() >= base + 2 * NWIN)
         for (int i = NWIN; i < 2 * NWIN; i++)
            check($sformatf("const50_%0d", i - NWIN), got_q[base+i].w, {25{8'd50}});

      // Frame abandoned by in_sof at pixel 20.
      base = got_q.size();
      fd0  = mon_fd;
      send_frame(1'b1, 8'd0, 1'b1, 0, 20);
      send_frame(1'b1, 8'd0, 1'b1, 20, W * H);
      idle(20);
      check("abort_nwin", got_q.size() - base, NWIN);
      check("abort_frame_done", mon_fd - fd0, 1);

      // Reset while a window is held by backpressure.
      send_frame(1'b1, 8'd0, 1'b1, 0, 36);
      send_pix(8'd36, 1'b0, 0);
      win_ready = 1'b0;
      in_valid  = 1'b0;
      #1;
      check("pre_rst_valid", win_valid, 1);
      rst = 1'b1;
      n_rst++;
      exp_q.delete();
      #1;
      check("rst_drops_valid", win_valid, 0);
      @(negedge clk);
      rst       = 1'b0;
      mc        = 0;
      mr        = 0;
      win_ready = 1'b1;
      @(negedge clk);
      base = got_q.size();
      send_frame(1'b1, 8'd0, 1'b0, 0, W * H);
      idle(10);
      check("post_rst_nwin", got_q.size() - base, NWIN);
      if (got_q.size() > base) begin
         check("post_rst_first_xy",  {got_q[base].x, got_q[base].y}, {16'd2, 16'd2});
         check("post_rst_first_ctr", got_q[base].w[103:96], 18);
      end

      // Back-to-back frames at full rate.
      base    = got_q.size();
      fd0     = mon_fd;
      max_run = 0;
      for (int f = 0; f < 3; f++) send_frame(1'b1, 8'd0, 1'b1, 0, W * H);
      idle(10);
      check("b2b_nwin",       got_q.size() - base, 3 * NWIN);
      check("b2b_frame_done", mon_fd - fd0, 3);
      check("b2b_run_len",    max_run, W - 4);

      check("fd_total",    mon_fd, exp_fd);
      check("queue_empty", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
